// File: rtl/two_cars_pkg.sv
// ---------------------------------------------------------------------------
// two_cars_pkg
// Shared types for the two-cars obstacle path: the spawn entry carried from
// the spawner FIFO to the renderer, the spawner FSM state encoding, and the
// lane/kind encoding constants.
// ---------------------------------------------------------------------------
package two_cars_pkg;

   // One queued obstacle: lane 0-1 belong to the left car, 2-3 to the right.
   typedef struct packed {
      logic [1:0] lane;
      logic       kind;
   } spawn_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_PUSH2  = 2'd3
   } spawner_state_t;

   // Flipping the lane MSB moves an obstacle to the mirrored lane of the
   // other car, which is how the second half of a burst is placed.
   localparam logic [1:0] LANE_BURST_FLIP = 2'b10;
   localparam logic       KIND_SQUARE     = 1'b0;
   localparam logic       KIND_CIRCLE     = 1'b1;

   // The companion entry of a burst: other car, opposite obstacle kind.
   function automatic spawn_entry_t burstPartner(input spawn_entry_t e);
      spawn_entry_t r;
      r.lane = e.lane ^ LANE_BURST_FLIP;
      r.kind = (e.kind == KIND_SQUARE) ? KIND_CIRCLE : KIND_SQUARE;
      return r;
   endfunction

endpackage

// File: rtl/spawn_fifo.sv
// ---------------------------------------------------------------------------
// spawn_fifo
// Small synchronous FIFO of spawn entries with an occupancy counter.
// A push while full is only taken when a pop happens in the same cycle.
//
// Ports:
//   Clk, Reset_n     clock / asynchronous active-low reset
//   push_i           request to store pushEntry_i
//   pushEntry_i      entry to store
//   pop_i            remove the head entry (ignored when empty)
//   head_o           entry at the read pointer
//   level_o          occupancy 0..DEPTH
//   full_o, empty_o  occupancy flags
// ---------------------------------------------------------------------------
module spawn_fifo
   import two_cars_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     push_i,
   input  spawn_entry_t             pushEntry_i,
   input  logic                     pop_i,
   output spawn_entry_t             head_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH) + 1;

   spawn_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wrPtr_q;
   logic [PW-1:0] rdPtr_q;
   logic [LW-1:0] level_q;
   logic          pushOk;
   logic          popOk;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign popOk   = pop_i & ~empty_o;
   // A pop in the same cycle frees the slot the push needs.
   assign pushOk  = push_i & (~full_o | popOk);
   assign head_o  = mem_q[rdPtr_q];
   assign level_o = level_q;

   // Storage, pointers and level; pointers wrap naturally at the power-of-two
   // depth. Storage is cleared on reset so nothing survives a reset.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         if (pushOk) begin
            mem_q[wrPtr_q] <= pushEntry_i;
            wrPtr_q        <= wrPtr_q + PW'(1);
         end
         if (popOk) begin
            rdPtr_q <= rdPtr_q + PW'(1);
         end
         case ({pushOk, popOk})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/obstacle_spawner.sv
// ---------------------------------------------------------------------------
// obstacle_spawner
// Consumes the LFSR random values once per spawn period and queues obstacle
// spawn events for the renderer through a valid/ready FIFO.
//
// Build option: define SPAWN_BURST_EN to let rand_a_num[2] request a second,
// mirrored entry (other car, opposite kind) one cycle after the first.
// Without it every decision produces exactly one entry.
//
// Ports:
//   Clk, Reset_n   clock / asynchronous active-low reset
//   enable         game running; low pauses scheduling (FIFO still drains)
//   frame_tick     one pulse per video frame
//   rand_a_num     [1:0] lane, [2] burst request
//   rand_b_num     obstacle kind (0 square, 1 circle)
//   spawn_ready    renderer accepts the head entry
//   spawn_valid    FIFO holds at least one entry
//   spawn_lane     lane of the head entry (0 when empty)
//   spawn_kind     kind of the head entry (0 when empty)
//   fifo_level     FIFO occupancy
//   overflow       sticky flag: an entry was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module obstacle_spawner
   import two_cars_pkg::*;
#(
   parameter int SPAWN_PERIOD = 60,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          Clk,
   input  logic                          Reset_n,
   input  logic                          enable,
   input  logic                          frame_tick,
   input  logic [2:0]                    rand_a_num,
   input  logic                          rand_b_num,
   input  logic                          spawn_ready,
   output logic                          spawn_valid,
   output logic [1:0]                    spawn_lane,
   output logic                          spawn_kind,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int            CW       = $clog2(SPAWN_PERIOD);
   localparam logic [CW-1:0] CNT_LAST = CW'(SPAWN_PERIOD - 1);

   spawner_state_t state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [CW-1:0]  cntInc;
   logic           overflow_q;
   logic           push;
   logic           pop;
   spawn_entry_t   pushEntry;
   spawn_entry_t   sampled;
   spawn_entry_t   headEntry;
   logic           fifoFull;
   logic           fifoEmpty;

`ifdef SPAWN_BURST_EN
   spawn_entry_t   capEntry_q, capEntry_d;
`else
   logic           unused_burst;
   assign unused_burst = rand_a_num[2];
`endif

   assign sampled.lane = rand_a_num[1:0];
   assign sampled.kind = rand_b_num;
   assign cntInc       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);

   // Scheduler: the period counter runs on frame ticks in every active state
   // so a tick landing in SAMPLE/PUSH2 is not lost. Dropping enable sends the
   // FSM home and abandons any burst half still to be pushed.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      push      = 1'b0;
      pushEntry = '0;
`ifdef SPAWN_BURST_EN
      capEntry_d = capEntry_q;
`endif
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (frame_tick) begin
                  cnt_d = cntInc;
                  if (cnt_q == CNT_LAST) begin
                     state_d = ST_SAMPLE;
                  end
               end
            end
            ST_SAMPLE: begin
               if (frame_tick) begin
                  cnt_d = cntInc;
               end
               push      = 1'b1;
               pushEntry = sampled;
`ifdef SPAWN_BURST_EN
               capEntry_d = sampled;
               state_d    = rand_a_num[2] ? ST_PUSH2 : ST_WAIT;
`else
               state_d    = ST_WAIT;
`endif
            end
            ST_PUSH2: begin
               if (frame_tick) begin
                  cnt_d = cntInc;
               end
`ifdef SPAWN_BURST_EN
               push      = 1'b1;
               pushEntry = burstPartner(capEntry_q);
`endif
               state_d = ST_WAIT;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, counter and sticky overflow registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
`ifdef SPAWN_BURST_EN
         capEntry_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_q | (push & fifoFull & ~pop);
`ifdef SPAWN_BURST_EN
         capEntry_q <= capEntry_d;
`endif
      end
   end

   assign pop = ~fifoEmpty & spawn_ready;

   spawn_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .push_i      (push),
      .pushEntry_i (pushEntry),
      .pop_i       (pop),
      .head_o      (headEntry),
      .level_o     (fifo_level),
      .full_o      (fifoFull),
      .empty_o     (fifoEmpty)
   );

   // Head fields are forced to zero while empty so idle outputs match reset.
   assign spawn_valid = ~fifoEmpty;
   assign spawn_lane  = fifoEmpty ? 2'b00 : headEntry.lane;
   assign spawn_kind  = fifoEmpty ? 1'b0  : headEntry.kind;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// ---------------------------------------------------------------------------
// tb_obstacle_spawner
// Self-checking bench for obstacle_spawner (SPAWN_PERIOD=3, FIFO_DEPTH=4).
// Directed scenarios followed by a randomized run against a queue-based
// reference model. Honours SPAWN_BURST_EN for burst expectations.
// ---------------------------------------------------------------------------
module tb_obstacle_spawner;

   localparam int P = 3;
   localparam int D = 4;
`ifdef SPAWN_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       enable;
   logic       frame_tick;
   logic [2:0] rand_a_num;
   logic       rand_b_num;
   logic       spawn_ready;
   logic       spawn_valid;
   logic [1:0] spawn_lane;
   logic       spawn_kind;
   logic [2:0] fifo_level;
   logic       overflow;

   int checks   = 0;
   int failures = 0;

   obstacle_spawner #(
      .SPAWN_PERIOD(P),
      .FIFO_DEPTH  (D)
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .enable     (enable),
      .frame_tick (frame_tick),
      .rand_a_num (rand_a_num),
      .rand_b_num (rand_b_num),
      .spawn_ready(spawn_ready),
      .spawn_valid(spawn_valid),
      .spawn_lane (spawn_lane),
      .spawn_kind (spawn_kind),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   always #5 Clk = ~Clk;

   // Drive one cycle of inputs (called at a falling edge) and return at the
   // next falling edge, when the outputs of that clock edge are settled.
   task automatic applyStimulus(input logic en, input logic tk, input logic [2:0] ra,
                                input logic rb, input logic rdy);
      enable      = en;
      frame_tick  = tk;
      rand_a_num  = ra;
      rand_b_num  = rb;
      spawn_ready = rdy;
      @(negedge Clk);
   endtask

   task automatic applyReset();
      Reset_n = 1'b0;
      enable = 1'b0; frame_tick = 1'b0; rand_a_num = 3'b000; rand_b_num = 1'b0; spawn_ready = 1'b0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   // One full decision from WAIT with cnt=0: P ticks, then the sample cycle.
   task automatic runDecision(input logic [2:0] ra, input logic rb, input logic rdySample);
      repeat (P) applyStimulus(1'b1, 1'b1, ra, rb, 1'b0);
      applyStimulus(1'b1, 1'b0, ra, rb, rdySample);
   endtask

   task automatic test_reset();
      applyReset();
      checks++; if (spawn_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b want=0", spawn_valid); end
      checks++; if (spawn_lane !== 2'd0) begin failures++; $display("[TB] FAIL reset_lane got=%0d want=0", spawn_lane); end
      checks++; if (spawn_kind !== 1'b0) begin failures++; $display("[TB] FAIL reset_kind got=%0b want=0", spawn_kind); end
      checks++; if (fifo_level !== 3'd0) begin failures++; $display("[TB] FAIL reset_level got=%0d want=0", fifo_level); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%0b want=0", overflow); end
   endtask

   task automatic test_single_spawn();
      applyReset();
      applyStimulus(1'b1, 1'b0, 3'b001, 1'b1, 1'b0);
      repeat (3) applyStimulus(1'b1, 1'b1, 3'b001, 1'b1, 1'b0);
      checks++; if (spawn_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_early_valid got=%0b want=0", spawn_valid); end
      applyStimulus(1'b1, 1'b0, 3'b001, 1'b1, 1'b0);
      checks++; if (spawn_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid got=%0b want=1", spawn_valid); end
      checks++; if (spawn_lane !== 2'd1) begin failures++; $display("[TB] FAIL single_lane got=%0d want=1", spawn_lane); end
      checks++; if (spawn_kind !== 1'b1) begin failures++; $display("[TB] FAIL single_kind got=%0b want=1", spawn_kind); end
      checks++; if (fifo_level !== 3'd1) begin failures++; $display("[TB] FAIL single_level got=%0d want=1", fifo_level); end
   endtask

   task automatic test_burst();
      logic [2:0] expLevel;
      applyReset();
      applyStimulus(1'b1, 1'b0, 3'b110, 1'b0, 1'b0);
      runDecision(3'b110, 1'b0, 1'b0);
      checks++; if (fifo_level !== 3'd1) begin failures++; $display("[TB] FAIL burst_first_level got=%0d want=1", fifo_level); end
      checks++; if (spawn_lane !== 2'd2 || spawn_kind !== 1'b0) begin failures++; $display("[TB] FAIL burst_first_entry got=%0d/%0b want=2/0", spawn_lane, spawn_kind); end
      // Random inputs change here; the second entry must come from the capture.
      applyStimulus(1'b1, 1'b0, 3'b001, 1'b1, 1'b0);
      expLevel = BURST ? 3'd2 : 3'd1;
      checks++; if (fifo_level !== expLevel) begin failures++; $display("[TB] FAIL burst_level got=%0d want=%0d", fifo_level, expLevel); end
      applyStimulus(1'b1, 1'b0, 3'b001, 1'b1, 1'b1);
      checks++; if (spawn_valid !== BURST || spawn_lane !== 2'd0 || spawn_kind !== BURST) begin
         failures++; $display("[TB] FAIL burst_second_entry got=%0b/%0d/%0b want=%0b/0/%0b", spawn_valid, spawn_lane, spawn_kind, BURST, BURST);
      end
   endtask

   task automatic test_overflow();
      applyReset();
      applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < D; i++) runDecision(3'(i), 1'(i & 1), 1'b0);
      checks++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_full got=%0d/%0b want=4/0", fifo_level, overflow); end
      runDecision(3'b011, 1'b1, 1'b0);
      checks++; if (fifo_level !== 3'd4) begin failures++; $display("[TB] FAIL ovf_level got=%0d want=4", fifo_level); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got=%0b want=1", overflow); end
      checks++; if (spawn_lane !== 2'd0 || spawn_kind !== 1'b0) begin failures++; $display("[TB] FAIL ovf_head got=%0d/%0b want=0/0", spawn_lane, spawn_kind); end
   endtask

   task automatic test_full_pop();
      int expLane[3];
      int expKind[3];
      expLane = '{2, 3, 2};
      expKind = '{0, 1, 1};
      applyReset();
      applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < D; i++) runDecision(3'(i), 1'(i & 1), 1'b0);
      runDecision(3'b010, 1'b1, 1'b1);
      checks++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL fullpop_state got=%0d/%0b want=4/0", fifo_level, overflow); end
      checks++; if (spawn_lane !== 2'd1 || spawn_kind !== 1'b1) begin failures++; $display("[TB] FAIL fullpop_head got=%0d/%0b want=1/1", spawn_lane, spawn_kind); end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
         checks++; if (spawn_lane !== 2'(expLane[i]) || spawn_kind !== 1'(expKind[i])) begin
            failures++; $display("[TB] FAIL fullpop_drain%0d got=%0d/%0b want=%0d/%0d", i, spawn_lane, spawn_kind, expLane[i], expKind[i]);
         end
      end
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
      checks++; if (fifo_level !== 3'd0 || spawn_valid !== 1'b0) begin failures++; $display("[TB] FAIL fullpop_empty got=%0d/%0b want=0/0", fifo_level, spawn_valid); end
   endtask

   task automatic test_pause();
      applyReset();
      applyStimulus(1'b1, 1'b0, 3'b001, 1'b0, 1'b0);
      runDecision(3'b001, 1'b0, 1'b0);
      runDecision(3'b001, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 3'b001, 1'b0, 1'b0);
      repeat (10) applyStimulus(1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
      checks++; if (fifo_level !== 3'd2) begin failures++; $display("[TB] FAIL pause_level got=%0d want=2", fifo_level); end
      applyStimulus(1'b0, 1'b0, 3'b001, 1'b0, 1'b1);
      checks++; if (fifo_level !== 3'd1) begin failures++; $display("[TB] FAIL pause_drain1 got=%0d want=1", fifo_level); end
      applyStimulus(1'b0, 1'b0, 3'b001, 1'b0, 1'b1);
      checks++; if (fifo_level !== 3'd0 || spawn_valid !== 1'b0) begin failures++; $display("[TB] FAIL pause_drain0 got=%0d/%0b want=0/0", fifo_level, spawn_valid); end
      applyStimulus(1'b1, 1'b0, 3'b011, 1'b1, 1'b0);
      repeat (P - 1) applyStimulus(1'b1, 1'b1, 3'b011, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 3'b011, 1'b1, 1'b0);
      checks++; if (fifo_level !== 3'd0) begin failures++; $display("[TB] FAIL pause_restart_early got=%0d want=0", fifo_level); end
      applyStimulus(1'b1, 1'b1, 3'b011, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 3'b011, 1'b1, 1'b0);
      checks++; if (fifo_level !== 3'd1 || spawn_lane !== 2'd3 || spawn_kind !== 1'b1) begin
         failures++; $display("[TB] FAIL pause_restart got=%0d/%0d/%0b want=1/3/1", fifo_level, spawn_lane, spawn_kind);
      end
   endtask

   task automatic test_reset_mid_burst();
      applyReset();
      applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
      runDecision(3'b000, 1'b0, 1'b0);
      runDecision(3'b001, 1'b1, 1'b0);
      runDecision(3'b101, 1'b1, 1'b0);
      checks++; if (fifo_level !== 3'd3) begin failures++; $display("[TB] FAIL midrst_pre_level got=%0d want=3", fifo_level); end
      Reset_n = 1'b0;
      #1;
      checks++; if (spawn_valid !== 1'b0 || fifo_level !== 3'd0 || spawn_lane !== 2'd0 || spawn_kind !== 1'b0 || overflow !== 1'b0) begin
         failures++; $display("[TB] FAIL midrst_outputs got=%0b/%0d/%0d/%0b/%0b want=0/0/0/0/0", spawn_valid, fifo_level, spawn_lane, spawn_kind, overflow);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
      repeat (P - 1) applyStimulus(1'b1, 1'b1, 3'b010, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
      checks++; if (fifo_level !== 3'd0) begin failures++; $display("[TB] FAIL midrst_no_spawn got=%0d want=0", fifo_level); end
      applyStimulus(1'b1, 1'b1, 3'b010, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
      checks++; if (fifo_level !== 3'd1 || spawn_lane !== 2'd2) begin failures++; $display("[TB] FAIL midrst_spawn got=%0d/%0d want=1/2", fifo_level, spawn_lane); end
   endtask

   // Randomized run. The model tracks what the current cycle does (stopped,
   // counting, deciding, pushing a burst partner) and keeps pending obstacles
   // as a queue of lane*2+kind values.
   task automatic test_random();
      int   mPhase;
      int   mCnt;
      int   mSaved;
      bit   mOvf;
      int   mQ[$];
      int   pushVal;
      bit   doPush;
      bit   en, tk, rb, rdy;
      logic [2:0] ra;
      int   expLane, expKind;
      applyReset();
      mPhase = 0; mCnt = 0; mSaved = 0; mOvf = 1'b0;
      mQ.delete();
      en = 1'b1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if ($urandom_range(0, 49) == 0) en = ~en;
         tk  = ($urandom_range(0, 2) == 0);
         ra  = 3'($urandom_range(0, 7));
         rb  = 1'($urandom_range(0, 1));
         rdy = ((cyc / 400) % 2 == 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
         doPush = 1'b0; pushVal = 0;
         if (!en) begin
            mPhase = 0;
         end else if (mPhase == 0) begin
            mCnt = 0; mPhase = 1;
         end else if (mPhase == 1) begin
            if (tk) begin
               if (mCnt == P - 1) begin mCnt = 0; mPhase = 2; end
               else mCnt = mCnt + 1;
            end
         end else if (mPhase == 2) begin
            doPush = 1'b1; pushVal = int'(ra[1:0]) * 2 + int'(rb);
            if (tk) mCnt = (mCnt + 1) % P;
            mSaved = pushVal;
            mPhase = (BURST && ra[2]) ? 3 : 1;
         end else begin
            doPush = 1'b1; pushVal = ((mSaved / 2) ^ 2) * 2 + (1 - (mSaved % 2));
            if (tk) mCnt = (mCnt + 1) % P;
            mPhase = 1;
         end
         if (rdy && mQ.size() > 0) void'(mQ.pop_front());
         if (doPush) begin
            if (mQ.size() < D) mQ.push_back(pushVal);
            else mOvf = 1'b1;
         end
         applyStimulus(en, tk, ra, rb, rdy);
         expLane = (mQ.size() > 0) ? mQ[0] / 2 : 0;
         expKind = (mQ.size() > 0) ? mQ[0] % 2 : 0;
         checks++; if (fifo_level !== 3'(mQ.size()) || spawn_valid !== (mQ.size() > 0)) begin
            failures++; $display("[TB] FAIL rand_level cyc=%0d got=%0d/%0b want=%0d", cyc, fifo_level, spawn_valid, mQ.size());
         end
         checks++; if (spawn_lane !== 2'(expLane) || spawn_kind !== 1'(expKind)) begin
            failures++; $display("[TB] FAIL rand_head cyc=%0d got=%0d/%0b want=%0d/%0d", cyc, spawn_lane, spawn_kind, expLane, expKind);
         end
         checks++; if (overflow !== mOvf) begin
            failures++; $display("[TB] FAIL rand_overflow cyc=%0d got=%0b want=%0b", cyc, overflow, mOvf);
         end
      end
   endtask

   initial begin
      @(negedge Clk);
      test_reset();
      test_single_spawn();
      test_burst();
      test_overflow();
      test_full_pop();
      test_pause();
      test_reset_mid_burst();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
